pos_clause_scheduler: RTL and testbench

//  Time-multiplexed evaluator for 2-literal product-of-sums clause groups (OR per clause pair, AND per group).

---
 rtl/pos_clause_scheduler_pkg.sv | 28 ++
 rtl/pos_clause_scheduler_if.sv | 35 +++
 rtl/pos_clause_scheduler_slice_eval.sv | 14 +
 rtl/pos_clause_scheduler.sv | 132 +++++++++++++
 tb/tb_pos_clause_scheduler.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pos_clause_scheduler_pkg.sv
// Shared types and default sizing for the clause scheduler.
//   state_e        : scheduler FSM states
//   DEF_*          : default configuration (4 groups x 16 clauses, 4 lanes, 8-bit counter)
//   SLICES/G_W/S_W : derived slice count and index widths for the defaults
//   idx_w()        : index width helper, never returns 0
package pos_sched_pkg;

  localparam int DEF_NUM_GROUPS = 4;
  localparam int DEF_CLAUSES    = 16;
  localparam int DEF_LANES      = 4;
  localparam int DEF_CNT_W      = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    DONE = 2'd2
  } state_e;

  // A one-entry index still needs a one-bit register.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int SLICES = DEF_CLAUSES / DEF_LANES;
  localparam int G_W    = idx_w(DEF_NUM_GROUPS);
  localparam int S_W    = idx_w(SLICES);

endpackage

// File: rtl/pos_clause_scheduler_if.sv
// Loader/collector-facing bundle of the clause scheduler.
//   flush, in_valid, lit_a, lit_b, out_ready        : driven by the master (loader/collector)
//   in_ready, out_valid, group_result, all_sat,
//   eval_cycles, busy                               : driven by the scheduler (slave)
interface pos_clause_scheduler_if
  import pos_sched_pkg::*;
#(
  parameter int NUM_GROUPS = DEF_NUM_GROUPS,
  parameter int CLAUSES    = DEF_CLAUSES,
  parameter int CNT_W      = DEF_CNT_W
) ();

  logic                          flush;
  logic                          in_valid;
  logic                          in_ready;
  logic [NUM_GROUPS*CLAUSES-1:0] lit_a;
  logic [NUM_GROUPS*CLAUSES-1:0] lit_b;
  logic                          out_valid;
  logic                          out_ready;
  logic [NUM_GROUPS-1:0]         group_result;
  logic                          all_sat;
  logic [CNT_W-1:0]              eval_cycles;
  logic                          busy;

  modport master (
    output flush, in_valid, lit_a, lit_b, out_ready,
    input  in_ready, out_valid, group_result, all_sat, eval_cycles, busy
  );

  modport slave (
    input  flush, in_valid, lit_a, lit_b, out_ready,
    output in_ready, out_valid, group_result, all_sat, eval_cycles, busy
  );

endinterface

// File: rtl/pos_clause_scheduler_slice_eval.sv
// One LANES-wide slice of 2-literal OR clauses ANDed together.
//   a, b : literal pairs of the slice
//   ok   : 1 iff every clause (a|b) in the slice is true
module pos_slice_eval #(
  parameter int LANES = 4
) (
  input  logic [LANES-1:0] a,
  input  logic [LANES-1:0] b,
  output logic             ok
);

  assign ok = &(a | b);

endmodule

// File: rtl/pos_clause_scheduler.sv
// Time-multiplexed product-of-sums evaluator. Captures one literal frame,
// then walks every group one LANES-wide slice per cycle, abandoning a group
// at its first false slice.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of pos_clause_scheduler_if (frame in, result out,
//                flush, busy)
module pos_clause_scheduler
  import pos_sched_pkg::*;
#(
  parameter int NUM_GROUPS = DEF_NUM_GROUPS,
  parameter int CLAUSES    = DEF_CLAUSES,
  parameter int LANES      = DEF_LANES,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  pos_clause_scheduler_if.slave   bus
);

  localparam int N_SLICES = CLAUSES / LANES;
  localparam int GW       = idx_w(NUM_GROUPS);
  localparam int SW       = idx_w(N_SLICES);

  generate
    if (CLAUSES % LANES != 0) begin : g_bad_lanes
      $error("CLAUSES must be a multiple of LANES");
    end
    if (NUM_GROUPS * N_SLICES > (1 << CNT_W) - 1) begin : g_bad_cnt
      $error("CNT_W too narrow for NUM_GROUPS*CLAUSES/LANES");
    end
  endgenerate

  // Packed so that flat bit g*CLAUSES+c lands at [g][c/LANES][c%LANES].
  typedef logic [NUM_GROUPS-1:0][N_SLICES-1:0][LANES-1:0] frame_t;

  state_e                state, state_nxt;
  frame_t                a_q, b_q;
  logic [GW-1:0]         g_q;
  logic [SW-1:0]         s_q;
  logic [NUM_GROUPS-1:0] res_q;
  logic [CNT_W-1:0]      cnt_q;

  logic                  slice_ok;
  logic                  last_s, last_g, grp_done, accept;
  logic                  in_ready_c, out_valid_c, busy_c;

  pos_slice_eval #(.LANES(LANES)) u_slice (
    .a  (a_q[g_q][s_q]),
    .b  (b_q[g_q][s_q]),
    .ok (slice_ok)
  );

  assign last_s   = (s_q == SW'(N_SLICES - 1));
  assign last_g   = (g_q == GW'(NUM_GROUPS - 1));
  // A false slice settles the group immediately; no point scanning the rest.
  assign grp_done = !slice_ok || last_s;
  // flush outranks a same-cycle frame.
  assign accept   = (state == IDLE) && bus.in_valid && !bus.flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    busy_c      = 1'b1;
    case (state)
      IDLE: begin
        in_ready_c = 1'b1;
        busy_c     = 1'b0;
        if (bus.in_valid) state_nxt = EVAL;
      end
      EVAL: begin
        if (grp_done && last_g) state_nxt = DONE;
      end
      DONE: begin
        out_valid_c = 1'b1;
        // Returning to IDLE first means a frame can never be taken while
        // out_valid is high.
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (bus.flush) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      g_q   <= '0;
      s_q   <= '0;
      res_q <= '0;
      cnt_q <= '0;
    end else if (bus.flush) begin
      a_q   <= '0;
      b_q   <= '0;
      g_q   <= '0;
      s_q   <= '0;
      res_q <= '0;
      cnt_q <= '0;
    end else if (accept) begin
      a_q   <= bus.lit_a;
      b_q   <= bus.lit_b;
      g_q   <= '0;
      s_q   <= '0;
      res_q <= '0;
      cnt_q <= '0;
    end else if (state == EVAL) begin
      cnt_q <= cnt_q + CNT_W'(1);
      if (!slice_ok)   res_q[g_q] <= 1'b0;
      else if (last_s) res_q[g_q] <= 1'b1;
      if (grp_done) begin
        s_q <= '0;
        g_q <= last_g ? '0 : g_q + GW'(1);
      end else begin
        s_q <= s_q + SW'(1);
      end
    end
  end

  assign bus.in_ready     = in_ready_c;
  assign bus.out_valid    = out_valid_c;
  assign bus.busy         = busy_c;
  assign bus.group_result = res_q;
  assign bus.all_sat      = &res_q;
  assign bus.eval_cycles  = cnt_q;

endmodule

// File: tb/tb_pos_clause_scheduler.sv
// Self-checking bench for pos_clause_scheduler: directed cases with literal
// expectations, then randomized frames/handshakes/flushes compared every
// cycle against a frame-level reference model.
module tb_pos_clause_scheduler;

  localparam int NG = 4, CL = 16, LN = 4, CW = 8;
  localparam int NB = NG * CL, NS = CL / LN;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pos_clause_scheduler_if #(.NUM_GROUPS(NG), .CLAUSES(CL), .CNT_W(CW)) bus ();

  pos_clause_scheduler #(.NUM_GROUPS(NG), .CLAUSES(CL), .LANES(LN), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Reference: a group is satisfied iff no clause is false; the scan of a
  // group costs one cycle per slice up to and including the slice holding
  // its first false clause.
  function automatic logic [NG-1:0] ref_res(input logic [NB-1:0] a, input logic [NB-1:0] b);
    logic [NB-1:0] t;
    logic [NG-1:0] r;
    t = a | b;
    for (int g = 0; g < NG; g++) r[g] = &t[g*CL +: CL];
    return r;
  endfunction

  function automatic int ref_ec(input logic [NB-1:0] a, input logic [NB-1:0] b);
    logic [NB-1:0] t;
    int ec, first;
    t = a | b;
    ec = 0;
    for (int g = 0; g < NG; g++) begin
      first = -1;
      for (int c = CL - 1; c >= 0; c--) if (!t[g*CL + c]) first = c;
      ec += (first < 0) ? NS : first / LN + 1;
    end
    return ec;
  endfunction

  // Frame-level model: 0 idle, 1 evaluating (m_rem cycles left), 2 result held.
  int            m_mode;
  int            m_rem;
  logic [NG-1:0] m_res;
  int            m_ec;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode <= 0; m_rem <= 0; m_res <= '0; m_ec <= 0;
    end else if (bus.flush) begin
      m_mode <= 0; m_res <= '0; m_ec <= 0;
    end else begin
      case (m_mode)
        0: if (bus.in_valid) begin
          m_res  <= ref_res(bus.lit_a, bus.lit_b);
          m_ec   <= ref_ec(bus.lit_a, bus.lit_b);
          m_rem  <= ref_ec(bus.lit_a, bus.lit_b);
          m_mode <= 1;
        end
        1: begin
          m_rem <= m_rem - 1;
          if (m_rem == 1) m_mode <= 2;
        end
        default: if (bus.out_ready) m_mode <= 0;
      endcase
    end
  end

  bit cmp_en = 1'b0;
  always @(negedge clk) begin
    if (rst_n && cmp_en) begin
      chk("cyc in_ready", bus.in_ready, m_mode == 0);
      chk("cyc busy", bus.busy, m_mode != 0);
      chk("cyc out_valid", bus.out_valid, m_mode == 2);
      if (m_mode != 1) begin
        chk("cyc group_result", bus.group_result, m_res);
        chk("cyc all_sat", bus.all_sat, &m_res);
        chk("cyc eval_cycles", bus.eval_cycles, m_ec);
      end
    end
  end

  task automatic run_frame(input string nm, input logic [NB-1:0] a, input logic [NB-1:0] b,
                           input int exp_lat, input logic [NG-1:0] exp_res, input int exp_ec);
    int lat;
    @(negedge clk);
    chk({nm, " in_ready"}, bus.in_ready, 1'b1);
    bus.in_valid = 1'b1; bus.lit_a = a; bus.lit_b = b; bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 100) begin @(negedge clk); lat++; end
    chk({nm, " latency"}, lat, exp_lat);
    chk({nm, " group_result"}, bus.group_result, exp_res);
    chk({nm, " all_sat"}, bus.all_sat, &exp_res);
    chk({nm, " eval_cycles"}, bus.eval_cycles, exp_ec);
  endtask

  task automatic gen(output logic [NB-1:0] a, output logic [NB-1:0] b);
    logic [NB-1:0] f;
    f = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
    if ($urandom_range(3) == 0) f = '0;
    a = {$urandom, $urandom} & ~f;
    b = ({$urandom, $urandom} | ~a) & ~f;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [NB-1:0] ones, zeros, a2, a7, ra, rb;
  int lat;

  initial begin
    ones  = '1;
    zeros = '0;
    a2    = ones; a2[1*CL + 5] = 1'b0;
    a7    = ones; a7[0*CL + 15] = 1'b0;
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.lit_a = '0; bus.lit_b = '0;

    // Pin the reference model with hand-derived values.
    chk("model all1 res", ref_res(ones, ones), 4'b1111);
    chk("model all1 ec", ref_ec(ones, ones), 16);
    chk("model g1c5 res", ref_res(a2, a2), 4'b1101);
    chk("model g1c5 ec", ref_ec(a2, a2), 14);
    chk("model all0 ec", ref_ec(zeros, zeros), 4);
    chk("model g0c15 res", ref_res(a7, a7), 4'b1110);

    #12;
    chk("rst in_ready", bus.in_ready, 1'b1);
    chk("rst out_valid", bus.out_valid, 1'b0);
    chk("rst busy", bus.busy, 1'b0);
    chk("rst group_result", bus.group_result, 4'b0000);
    chk("rst eval_cycles", bus.eval_cycles, 8'd0);
    chk("rst all_sat", bus.all_sat, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    cmp_en = 1'b1;

    run_frame("all1", ones, ones, 17, 4'b1111, 16);
    run_frame("g1c5", a2, a2, 15, 4'b1101, 14);
    run_frame("all0", zeros, zeros, 5, 4'b0000, 4);
    run_frame("g0c15", a7, ones & ~(64'd1 << 15), 17, 4'b1110, 16);

    // Result held for 5 cycles, then a frame presented together with out_ready.
    @(negedge clk);
    bus.in_valid = 1'b1; bus.lit_a = a2; bus.lit_b = a2; bus.out_ready = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 100) begin @(negedge clk); lat++; end
    chk("hold latency", lat, 15);
    repeat (5) begin
      @(negedge clk);
      chk("hold out_valid", bus.out_valid, 1'b1);
      chk("hold in_ready", bus.in_ready, 1'b0);
      chk("hold group_result", bus.group_result, 4'b1101);
      chk("hold eval_cycles", bus.eval_cycles, 8'd14);
    end
    bus.out_ready = 1'b1; bus.in_valid = 1'b1; bus.lit_a = ones; bus.lit_b = zeros;
    @(negedge clk);
    chk("release no accept busy", bus.busy, 1'b0);
    chk("release in_ready", bus.in_ready, 1'b1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("release accepted busy", bus.busy, 1'b1);
    lat = 0;
    while (bus.busy && lat < 100) begin @(negedge clk); lat++; end
    chk("release frame done", bus.busy, 1'b0);

    // Flush on the third EVAL cycle.
    @(negedge clk);
    bus.in_valid = 1'b1; bus.lit_a = ones; bus.lit_b = ones;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    chk("flush in_ready", bus.in_ready, 1'b1);
    chk("flush busy", bus.busy, 1'b0);
    chk("flush out_valid", bus.out_valid, 1'b0);
    chk("flush eval_cycles", bus.eval_cycles, 8'd0);
    chk("flush group_result", bus.group_result, 4'b0000);
    run_frame("after flush", ones, ones, 17, 4'b1111, 16);

    // Reset mid-EVAL.
    @(negedge clk);
    bus.in_valid = 1'b1; bus.lit_a = ones; bus.lit_b = ones;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst in_ready", bus.in_ready, 1'b1);
    chk("midrst busy", bus.busy, 1'b0);
    chk("midrst eval_cycles", bus.eval_cycles, 8'd0);
    chk("midrst group_result", bus.group_result, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;

    // flush with in_valid in IDLE: frame dropped.
    @(negedge clk);
    bus.flush = 1'b1; bus.in_valid = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    chk("flush+valid busy", bus.busy, 1'b0);
    @(negedge clk);
    chk("flush+valid busy later", bus.busy, 1'b0);

    // Randomized traffic; the per-cycle compare does the checking.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      gen(ra, rb);
      bus.lit_a     = ra;
      bus.lit_b     = rb;
      bus.in_valid  = ($urandom_range(3) != 0);
      bus.out_ready = ($urandom_range(2) != 0);
      bus.flush     = ($urandom_range(63) == 0);
    end
    @(negedge clk);
    bus.in_valid = 1'b0; bus.flush = 1'b0; bus.out_ready = 1'b1;
    lat = 0;
    while (bus.busy && lat < 100) begin @(negedge clk); lat++; end
    chk("drain idle", bus.busy, 1'b0);
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
